// File: rtl/des_pkg.sv
// des_pkg: shared types, constants and the DES round function used by both cores
package des_pkg;

    typedef enum logic [1:0] {IDLE, ACCEPT, COMPUTE, EMIT} state_e;
    typedef logic [63:0] block_t;

    localparam logic MODE_ENC = 1'b0;
    localparam logic MODE_DEC = 1'b1;

    localparam int IP_T [64] = '{58,50,42,34,26,18,10,2, 60,52,44,36,28,20,12,4,
                                 62,54,46,38,30,22,14,6, 64,56,48,40,32,24,16,8,
                                 57,49,41,33,25,17,9,1,  59,51,43,35,27,19,11,3,
                                 61,53,45,37,29,21,13,5, 63,55,47,39,31,23,15,7};
    localparam int FP_T [64] = '{40,8,48,16,56,24,64,32, 39,7,47,15,55,23,63,31,
                                 38,6,46,14,54,22,62,30, 37,5,45,13,53,21,61,29,
                                 36,4,44,12,52,20,60,28, 35,3,43,11,51,19,59,27,
                                 34,2,42,10,50,18,58,26, 33,1,41,9,49,17,57,25};
    localparam int E_T [48] = '{32,1,2,3,4,5, 4,5,6,7,8,9, 8,9,10,11,12,13, 12,13,14,15,16,17,
                                16,17,18,19,20,21, 20,21,22,23,24,25, 24,25,26,27,28,29, 28,29,30,31,32,1};
    localparam int P_T [32] = '{16,7,20,21,29,12,28,17, 1,15,23,26,5,18,31,10,
                                2,8,24,14,32,27,3,9, 19,13,30,6,22,11,4,25};
    localparam int PC1_T [56] = '{57,49,41,33,25,17,9, 1,58,50,42,34,26,18,
                                  10,2,59,51,43,35,27, 19,11,3,60,52,44,36,
                                  63,55,47,39,31,23,15, 7,62,54,46,38,30,22,
                                  14,6,61,53,45,37,29, 21,13,5,28,20,12,4};
    localparam int PC2_T [48] = '{14,17,11,24,1,5, 3,28,15,6,21,10, 23,19,12,4,26,8, 16,7,27,20,13,2,
                                  41,52,31,37,47,55, 30,40,51,45,33,48, 44,49,39,56,34,53, 46,42,50,36,29,32};
    // Rounds whose key halves rotate by two (MSB = round 1)
    localparam logic [15:0] SH2 = 16'b0011111101111110;
    // S-boxes: 64 nibbles each, row-major with row 0 in the top bits
    localparam logic [255:0] SBOX [8] = '{
        256'hE4D12FB83A6C5907_0F74E2D1A6CB9538_41E8D62BFC973A50_FC8249175B3EA06D,
        256'hF18E6B34972DC05A_3D47F28EC01A69B5_0E7BA4D158C6932F_D8A13F42B67C05E9,
        256'hA09E63F51DC7B428_D709346A285ECBF1_D6498F30B12C5AE7_1AD069874FE3B52C,
        256'h7DE3069A1285BC4F_D8B56F03472C1AE9_A690CB7DF13E5284_3F06A1D8945BC72E,
        256'h2C417AB6853FD0E9_EB2C47D150FA3986_421BAD78F9C5630E_B8C71E2D6F09A453,
        256'hC1AF92680D34E75B_AF427C9561DE0B38_9EF528C3704A1DB6_432C95FABE17608D,
        256'h4B2EF08D3C975A61_D0B7491AE35C2F86_14BDC37EAF680592_6BD814A7950FE23C,
        256'hD2846FB1A93E50C7_1FD8A374C56B0E92_7B419CE206ADF358_21E74A8DFC90356B};

    // Single-block DES; dec reverses the subkey order. Table entries use DES bit 1 = MSB.
    function automatic block_t des_crypt(input block_t blk, input block_t key, input logic dec);
        logic [55:0] cd;
        logic [27:0] c, d;
        logic [47:0] ks [16];
        logic [47:0] x;
        logic [31:0] l, r, t, f, s;
        logic [5:0]  b;
        block_t      ip, pre, res;
        for (int i = 0; i < 56; i++) cd[55-i] = key[64-PC1_T[i]];
        c = cd[55:28];
        d = cd[27:0];
        for (int n = 0; n < 16; n++) begin
            c = SH2[15-n] ? {c[25:0], c[27:26]} : {c[26:0], c[27]};
            d = SH2[15-n] ? {d[25:0], d[27:26]} : {d[26:0], d[27]};
            cd = {c, d};
            for (int i = 0; i < 48; i++) ks[n][47-i] = cd[56-PC2_T[i]];
        end
        for (int i = 0; i < 64; i++) ip[63-i] = blk[64-IP_T[i]];
        l = ip[63:32];
        r = ip[31:0];
        for (int n = 0; n < 16; n++) begin
            for (int i = 0; i < 48; i++) x[47-i] = r[32-E_T[i]];
            x = x ^ ks[dec ? 15-n : n];
            for (int j = 0; j < 8; j++) begin
                b = x[47-6*j -: 6];
                s[31-4*j -: 4] = SBOX[j][255-4*int'({b[5], b[0], b[4:1]}) -: 4];
            end
            for (int i = 0; i < 32; i++) f[31-i] = s[32-P_T[i]];
            t = r;
            r = l ^ f;
            l = t;
        end
        pre = {r, l};
        for (int i = 0; i < 64; i++) res[63-i] = pre[64-FP_T[i]];
        return res;
    endfunction

endpackage

// File: rtl/DES_decrypt.sv
// DES_decrypt: combinational single-block DES decryptor
module DES_decrypt
    import des_pkg::*;
(
    input  logic [63:0] CIPHER_TEXT,
    input  logic [63:0] KEY,
    output logic [63:0] PLAIN_TEXT
);
    assign PLAIN_TEXT = des_crypt(CIPHER_TEXT, KEY, 1'b1);
endmodule

// File: rtl/DES_top.sv
// DES_top: combinational single-block DES encryptor
module DES_top
    import des_pkg::*;
(
    input  logic [63:0] PLAIN_TEXT,
    input  logic [63:0] KEY,
    output logic [63:0] CIPHER_TEXT
);
    assign CIPHER_TEXT = des_crypt(PLAIN_TEXT, KEY, 1'b0);
endmodule

// File: rtl/des_cbc_ctrl.sv
// des_cbc_ctrl: CBC chaining controller driving the combinational DES cores
module des_cbc_ctrl
    import des_pkg::*;
#(
    parameter int CORE_LAT = 2
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        START,
    input  logic        MODE,
    input  logic [63:0] KEY,
    input  logic [63:0] IV,
    input  logic        IN_VALID,
    output logic        IN_READY,
    input  logic [63:0] IN_DATA,
    input  logic        IN_LAST,
    output logic        OUT_VALID,
    input  logic        OUT_READY,
    output logic [63:0] OUT_DATA,
    output logic        OUT_LAST,
    output logic        BUSY
);
    localparam int CW = $clog2(CORE_LAT + 1);

    state_e        state_q;
    block_t        key_q, chain_q, core_in_q, ct_q, out_q;
    logic          mode_q, last_q;
    logic [CW-1:0] cnt_q;
    block_t        enc_ct, dec_pt;

    DES_top     u_enc (.PLAIN_TEXT(core_in_q), .KEY(key_q), .CIPHER_TEXT(enc_ct));
    DES_decrypt u_dec (.CIPHER_TEXT(core_in_q), .KEY(key_q), .PLAIN_TEXT(dec_pt));

    assign IN_READY  = state_q == ACCEPT;
    assign OUT_VALID = state_q == EMIT;
    assign BUSY      = state_q != IDLE;
    assign OUT_DATA  = out_q;
    assign OUT_LAST  = last_q;

    // Message FSM: latch context, accept a block, wait out the core, hold the result
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q   <= IDLE;
            key_q     <= '0;
            chain_q   <= '0;
            core_in_q <= '0;
            ct_q      <= '0;
            out_q     <= '0;
            mode_q    <= 1'b0;
            last_q    <= 1'b0;
            cnt_q     <= '0;
        end else begin
            case (state_q)
                IDLE: if (START) begin
                    key_q   <= KEY;
                    chain_q <= IV;
                    mode_q  <= MODE;
                    state_q <= ACCEPT;
                end
                ACCEPT: if (IN_VALID) begin
                    core_in_q <= mode_q == MODE_DEC ? IN_DATA : IN_DATA ^ chain_q;
                    if (mode_q == MODE_DEC) ct_q <= IN_DATA;
                    last_q  <= IN_LAST;
                    cnt_q   <= '0;
                    state_q <= COMPUTE;
                end
                COMPUTE: begin
                    cnt_q <= cnt_q + CW'(1);
                    if (cnt_q == CW'(CORE_LAT - 1)) begin
                        out_q   <= mode_q == MODE_DEC ? dec_pt ^ chain_q : enc_ct;
                        chain_q <= mode_q == MODE_DEC ? ct_q : enc_ct;
                        state_q <= EMIT;
                    end
                end
                EMIT: if (OUT_READY) state_q <= last_q ? IDLE : ACCEPT;
                default: state_q <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_des_cbc_ctrl.sv
// tb_des_cbc_ctrl: directed CBC scenarios with a scoreboard queue of expected outputs
module tb_des_cbc_ctrl;
    localparam int LAT = 3;
    localparam logic [63:0] K  = 64'h133457799BBCDFF1;
    localparam logic [63:0] P1 = 64'h0123456789ABCDEF;
    localparam logic [63:0] P2 = 64'h84CB563386A179EA;
    localparam logic [63:0] C1 = 64'h85E813540F0AB405;

    logic        CLK = 1'b0, RST, START, MODE, IN_VALID, IN_READY, IN_LAST;
    logic        OUT_VALID, OUT_READY, OUT_LAST, BUSY;
    logic [63:0] KEY, IV, IN_DATA, OUT_DATA;
    logic [64:0] sbq [$];
    int          n_vec = 0, n_err = 0;

    des_cbc_ctrl #(.CORE_LAT(LAT)) dut (
        .CLK(CLK), .RST(RST), .START(START), .MODE(MODE), .KEY(KEY), .IV(IV),
        .IN_VALID(IN_VALID), .IN_READY(IN_READY), .IN_DATA(IN_DATA), .IN_LAST(IN_LAST),
        .OUT_VALID(OUT_VALID), .OUT_READY(OUT_READY), .OUT_DATA(OUT_DATA),
        .OUT_LAST(OUT_LAST), .BUSY(BUSY));

    always #5 CLK = ~CLK;

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic start_msg(input logic [63:0] iv, input logic mode);
        KEY = K;
        IV = iv;
        MODE = mode;
        START = 1'b1;
        tick();
        START = 1'b0;
        chk("start_in_ready", 64'(IN_READY), 64'd1);
        chk("start_busy", 64'(BUSY), 64'd1);
    endtask

    // Drive one block, push its expected result, then follow it to the output handshake
    task automatic do_block(input logic [63:0] d, input logic l, input logic [63:0] exp, input int hold);
        int          w, lat;
        logic [64:0] e;
        logic [63:0] sd;
        logic        sl;
        w = 0;
        while (!IN_READY && w < 20) begin tick(); w++; end
        chk("in_ready_wait", 64'(IN_READY), 64'd1);
        IN_DATA = d;
        IN_LAST = l;
        IN_VALID = 1'b1;
        sbq.push_back({l, exp});
        tick();
        IN_VALID = 1'b0;
        IN_DATA = '1;
        IN_LAST = ~l;
        lat = 1;
        while (!OUT_VALID && lat < 50) begin
            chk("overlap_ready", 64'(IN_READY), 64'd0);
            tick();
            lat++;
        end
        chk("latency", 64'(lat), 64'(LAT + 1));
        chk("emit_in_ready", 64'(IN_READY), 64'd0);
        if (hold > 0) begin
            OUT_READY = 1'b0;
            sd = OUT_DATA;
            sl = OUT_LAST;
            for (int k = 0; k < hold; k++) begin
                START = k == 1;
                KEY = 64'h0;
                IV = '1;
                MODE = ~MODE;
                tick();
                START = 1'b0;
                chk("bp_data", OUT_DATA, sd);
                chk("bp_last", 64'(OUT_LAST), 64'(sl));
                chk("bp_valid", 64'(OUT_VALID), 64'd1);
                chk("bp_in_ready", 64'(IN_READY), 64'd0);
            end
            KEY = K;
            OUT_READY = 1'b1;
        end
        e = sbq.size() > 0 ? sbq.pop_front() : 65'h0;
        chk("out_data", OUT_DATA, e[63:0]);
        chk("out_last", 64'(OUT_LAST), 64'(e[64]));
        tick();
        if (l) chk("end_busy", 64'(BUSY), 64'd0);
        else chk("next_in_ready", 64'(IN_READY), 64'd1);
        chk("post_out_valid", 64'(OUT_VALID), 64'd0);
    endtask

    initial begin
        int seen;
        RST = 1'b1; START = 1'b0; MODE = 1'b0; KEY = '0; IV = '0;
        IN_VALID = 1'b0; IN_DATA = '0; IN_LAST = 1'b0; OUT_READY = 1'b1;
        tick();
        tick();
        RST = 1'b0;
        chk("rst_in_ready", 64'(IN_READY), 64'd0);
        chk("rst_out_valid", 64'(OUT_VALID), 64'd0);
        chk("rst_out_data", OUT_DATA, 64'd0);
        chk("rst_out_last", 64'(OUT_LAST), 64'd0);
        chk("rst_busy", 64'(BUSY), 64'd0);
        start_msg(64'h0, 1'b0);
        do_block(P1, 1'b1, C1, 0);
        start_msg(64'h0, 1'b1);
        do_block(C1, 1'b1, P1, 0);
        start_msg(64'h0, 1'b0);
        do_block(P1, 1'b0, C1, 0);
        do_block(P2, 1'b1, C1, 0);
        start_msg(64'h0, 1'b1);
        do_block(C1, 1'b0, P1, 0);
        do_block(C1, 1'b1, P2, 0);
        start_msg(64'h0, 1'b0);
        do_block(P1, 1'b0, C1, 5);
        do_block(P2, 1'b1, C1, 0);
        start_msg(64'h0, 1'b0);
        IN_DATA = P2;
        IN_LAST = 1'b1;
        IN_VALID = 1'b1;
        tick();
        IN_VALID = 1'b0;
        tick();
        RST = 1'b1;
        tick();
        RST = 1'b0;
        chk("midrst_busy", 64'(BUSY), 64'd0);
        chk("midrst_in_ready", 64'(IN_READY), 64'd0);
        chk("midrst_out_valid", 64'(OUT_VALID), 64'd0);
        chk("midrst_out_data", OUT_DATA, 64'd0);
        chk("midrst_out_last", 64'(OUT_LAST), 64'd0);
        seen = 0;
        for (int k = 0; k < LAT + 4; k++) begin
            tick();
            if (OUT_VALID) seen++;
        end
        chk("midrst_no_output", 64'(seen), 64'd0);
        start_msg(64'h0, 1'b0);
        do_block(P1, 1'b1, C1, 0);
        chk("scoreboard_empty", 64'(sbq.size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
